// File: rtl/rom_dl_sequencer_pkg.sv
// Shared types and image layout constants for the ROM download sequencer.
package rom_dl_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_DONE,
    ST_ERR
  } dl_state_e;

  localparam int unsigned ROM_AW      = 17;
  localparam int unsigned ROM_DW      = 8;

  // Download image layout: main CPU ROM, sub CPU ROM, wave ROM.
  localparam logic [16:0] MROM_BASE   = 17'h00000;
  localparam logic [16:0] SROM_BASE   = 17'h10000;
  localparam logic [16:0] WAVE_BASE   = 17'h13500;
  localparam logic [16:0] IMG_LEN_DEF = 17'h13600;

endpackage

// File: rtl/rom_dl_sequencer_sync_fifo.sv
// Small synchronous FIFO with asynchronous reset and synchronous clear.
module sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; clear wins over push/pop.
  always_comb begin
    do_push  = push & ~full & ~clr;
    do_pop   = pop & ~empty & ~clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rom_dl_sequencer.sv
// ROM download transmitter: buffers loader bytes, issues paced ROM writes,
// and holds the game core in reset until a full image has been written.
module rom_dl_sequencer
  import rom_dl_sequencer_pkg::*;
#(
  parameter logic [16:0] IMG_LEN  = IMG_LEN_DEF,
  parameter int unsigned FIFO_AW  = 2,
  parameter int unsigned WR_GAP   = 2,
  parameter int unsigned POST_RST = 16
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        DL_START,
  input  logic        DL_END,
  input  logic [3:0]  TNO_IN,
  input  logic        DL_VALID,
  input  logic [7:0]  DL_DATA,
  output logic        DL_READY,
  output logic        ROMCL,
  output logic [16:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic [3:0]  TNO,
  output logic        CORE_RESET,
  output logic        DL_BUSY,
  output logic        DL_DONE,
  output logic        DL_ERR
);

  localparam int unsigned GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam int unsigned HW = (POST_RST > 1) ? $clog2(POST_RST) : 1;
  localparam logic [FIFO_AW:0] FIFO_DEPTH = (FIFO_AW+1)'(2 ** FIFO_AW);

  dl_state_e       state_q, state_d;
  logic [16:0]     in_cnt_q, in_cnt_d;
  logic [16:0]     wr_addr_q, wr_addr_d;
  logic [16:0]     romad_q, romad_d;
  logic [7:0]      romdt_q, romdt_d;
  logic            romen_q, romen_d;
  logic [3:0]      tno_q, tno_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            dl_ready_q, dl_ready_d;
  logic            core_reset_q, core_reset_d;
  logic            dl_busy_q, dl_busy_d;
  logic            dl_done_q, dl_done_d;
  logic            dl_err_q, dl_err_d;

  logic            accept, engine_on, wr_fire, bypass, last_wr;
  logic            f_clr, f_push, f_pop, f_full, f_empty;
  logic [7:0]      f_dout;
  logic [FIFO_AW:0] f_count, f_cnt_nxt;

  sync_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (MCLK),
    .rst   (RESET),
    .clr   (f_clr),
    .push  (f_push),
    .pop   (f_pop),
    .din   (DL_DATA),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign accept = DL_VALID & dl_ready_q;

  // Write engine and counters. A byte arriving at an empty FIFO with the gap
  // expired bypasses the FIFO so it reaches ROMEN one cycle after acceptance.
  always_comb begin
    engine_on = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && !DL_START;
    wr_fire   = engine_on && (gap_cnt_q == '0) && (!f_empty || accept);
    bypass    = wr_fire && f_empty;
    last_wr   = wr_fire && (wr_addr_q == IMG_LEN - 17'd1);
    f_clr     = DL_START;
    f_push    = accept && !bypass && !DL_START;
    f_pop     = wr_fire && !f_empty;

    in_cnt_d   = in_cnt_q;
    wr_addr_d  = wr_addr_q;
    romad_d    = romad_q;
    romdt_d    = romdt_q;
    romen_d    = 1'b0;
    tno_d      = tno_q;
    gap_cnt_d  = (gap_cnt_q != '0) ? gap_cnt_q - GW'(1) : gap_cnt_q;
    hold_cnt_d = (state_q == ST_HOLD && !DL_START) ? hold_cnt_q + HW'(1) : '0;

    if (DL_START) begin
      in_cnt_d  = '0;
      wr_addr_d = '0;
      gap_cnt_d = '0;
      tno_d     = TNO_IN;
    end else begin
      if (accept) in_cnt_d = in_cnt_q + 17'd1;
      if (wr_fire) begin
        romen_d   = 1'b1;
        romad_d   = wr_addr_q;
        romdt_d   = bypass ? DL_DATA : f_dout;
        gap_cnt_d = GW'(WR_GAP - 1);
        if (!last_wr) wr_addr_d = wr_addr_q + 17'd1;
      end
    end
  end

  // Next-state logic. The final write can fire in LOAD through the bypass,
  // in which case DRAIN has nothing left to wait for and is skipped.
  always_comb begin
    state_d = state_q;
    if (DL_START) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_cnt_d == IMG_LEN) state_d = last_wr ? ST_HOLD : ST_DRAIN;
          else if (DL_END)         state_d = ST_ERR;
        end
        ST_DRAIN: if (last_wr) state_d = ST_HOLD;
        ST_HOLD:  if (hold_cnt_q == HW'(POST_RST - 1)) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Registered outputs derived from the upcoming state and FIFO occupancy.
  always_comb begin
    f_cnt_nxt    = DL_START ? '0
                 : f_count + (FIFO_AW+1)'(f_push) - (FIFO_AW+1)'(f_pop);
    dl_busy_d    = (state_d == ST_LOAD) || (state_d == ST_DRAIN) || (state_d == ST_HOLD);
    dl_done_d    = (state_d == ST_DONE);
    dl_err_d     = (state_d == ST_ERR);
    core_reset_d = (state_d != ST_DONE);
    dl_ready_d   = (state_d == ST_LOAD) && (in_cnt_d < IMG_LEN) && (f_cnt_nxt < FIFO_DEPTH);
  end

  // State register.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      in_cnt_q     <= '0;
      wr_addr_q    <= '0;
      romad_q      <= '0;
      romdt_q      <= '0;
      romen_q      <= 1'b0;
      tno_q        <= '0;
      gap_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      dl_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      dl_busy_q    <= 1'b0;
      dl_done_q    <= 1'b0;
      dl_err_q     <= 1'b0;
    end else begin
      in_cnt_q     <= in_cnt_d;
      wr_addr_q    <= wr_addr_d;
      romad_q      <= romad_d;
      romdt_q      <= romdt_d;
      romen_q      <= romen_d;
      tno_q        <= tno_d;
      gap_cnt_q    <= gap_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      dl_ready_q   <= dl_ready_d;
      core_reset_q <= core_reset_d;
      dl_busy_q    <= dl_busy_d;
      dl_done_q    <= dl_done_d;
      dl_err_q     <= dl_err_d;
    end
  end

  assign ROMCL      = MCLK;
  assign DL_READY   = dl_ready_q;
  assign ROMAD      = romad_q;
  assign ROMDT      = romdt_q;
  assign ROMEN      = romen_q;
  assign TNO        = tno_q;
  assign CORE_RESET = core_reset_q;
  assign DL_BUSY    = dl_busy_q;
  assign DL_DONE    = dl_done_q;
  assign DL_ERR     = dl_err_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Scoreboard bench: the loader driver pushes the expected ROM write for every
// accepted byte (image byte k lands at address k); a monitor pops and compares
// on every ROMEN. A reduced image length keeps the run short.
module tb_rom_dl_sequencer;

  localparam logic [16:0] IMG      = 17'h400;
  localparam int unsigned GAP      = 2;
  localparam int unsigned POST     = 16;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DL_START = 1'b0;
  logic        DL_END = 1'b0;
  logic [3:0]  TNO_IN = '0;
  logic        DL_VALID = 1'b0;
  logic [7:0]  DL_DATA = '0;
  logic        DL_READY, ROMCL, ROMEN, CORE_RESET, DL_BUSY, DL_DONE, DL_ERR;
  logic [16:0] ROMAD;
  logic [7:0]  ROMDT;
  logic [3:0]  TNO;

  rom_dl_sequencer #(
    .IMG_LEN  (IMG),
    .FIFO_AW  (2),
    .WR_GAP   (GAP),
    .POST_RST (POST)
  ) dut (
    .MCLK       (MCLK),
    .RESET      (RESET),
    .DL_START   (DL_START),
    .DL_END     (DL_END),
    .TNO_IN     (TNO_IN),
    .DL_VALID   (DL_VALID),
    .DL_DATA    (DL_DATA),
    .DL_READY   (DL_READY),
    .ROMCL      (ROMCL),
    .ROMAD      (ROMAD),
    .ROMDT      (ROMDT),
    .ROMEN      (ROMEN),
    .TNO        (TNO),
    .CORE_RESET (CORE_RESET),
    .DL_BUSY    (DL_BUSY),
    .DL_DONE    (DL_DONE),
    .DL_ERR     (DL_ERR)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    int          ep;
    logic [16:0] addr;
    logic [7:0]  data;
    longint      cyc;
  } item_t;

  item_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  int          epoch = 0;
  int          wr_epoch = 0;
  int unsigned img_idx = 0;
  bit          strict_gap = 1'b0;
  int          cur_ep = -1;
  int unsigned wr_cnt = 0;
  longint      last_wr_cyc = 0;

  initial forever begin
    @(posedge MCLK);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // Monitor: every ROM write must match the next byte of the current image.
  initial forever begin
    item_t it;
    @(negedge MCLK);
    if (ROMEN === 1'b1) begin
      while (exp_q.size() > 0 && exp_q[0].ep < wr_epoch) void'(exp_q.pop_front());
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: ROMAD=0x%0h ROMDT=0x%0h with no byte pending", ROMAD, ROMDT);
      end else begin
        it = exp_q.pop_front();
        chk("romad_range", longint'(ROMAD < IMG), 1);
        chk("romad", ROMAD, it.addr);
        chk("romdt", ROMDT, it.data);
        if (it.ep != cur_ep) begin
          cur_ep = it.ep;
          wr_cnt = 0;
          chk("first_write_latency", cyc - it.cyc, 1);
        end else if (strict_gap) begin
          chk("write_spacing", cyc - last_wr_cyc, GAP);
        end else begin
          chk("write_spacing_min", longint'((cyc - last_wr_cyc) >= GAP), 1);
        end
        wr_cnt++;
        last_wr_cyc = cyc;
      end
    end
  end

  task automatic do_start(input logic [3:0] tno);
    DL_VALID = 1'b0;
    DL_START = 1'b1;
    TNO_IN   = tno;
    epoch++;
    img_idx  = 0;
    tick();
    DL_START = 1'b0;
    wr_epoch = epoch;
  endtask

  // Offer bytes with probability pct% per cycle until n have been accepted.
  task automatic send_bytes(input int unsigned n, input int unsigned pct);
    int unsigned acc = 0;
    int unsigned budget = 0;
    while (acc < n && budget < 20000) begin
      DL_VALID = ($urandom_range(99) < pct);
      DL_DATA  = 8'($urandom);
      if (DL_VALID && DL_READY) begin
        exp_q.push_back('{ep: epoch, addr: 17'(img_idx), data: DL_DATA, cyc: cyc});
        img_idx++;
        acc++;
      end
      tick();
      budget++;
    end
    DL_VALID = 1'b0;
    if (acc < n) chk("send_timeout", acc, n);
  endtask

  // Wait for DL_DONE, optionally still offering bytes beyond the image end.
  task automatic wait_done(input bit keep_valid, output longint done_cyc, output int unsigned extra);
    int unsigned n = 0;
    extra    = 0;
    done_cyc = -1;
    DL_VALID = keep_valid;
    while (DL_DONE !== 1'b1 && n < 5000) begin
      DL_DATA = 8'($urandom);
      if (DL_VALID && DL_READY) extra++;
      tick();
      n++;
    end
    DL_VALID = 1'b0;
    if (DL_DONE === 1'b1) done_cyc = cyc;
    else chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, DL_READY, 0);
    chk({tag, "_romad"}, ROMAD, 0);
    chk({tag, "_romdt"}, ROMDT, 0);
    chk({tag, "_romen"}, ROMEN, 0);
    chk({tag, "_tno"}, TNO, 0);
    chk({tag, "_core_reset"}, CORE_RESET, 1);
    chk({tag, "_busy"}, DL_BUSY, 0);
    chk({tag, "_done"}, DL_DONE, 0);
    chk({tag, "_err"}, DL_ERR, 0);
  endtask

  task automatic chk_complete(input string tag, input logic [3:0] tno);
    longint      dc;
    int unsigned extra;
    wait_done(1'b1, dc, extra);
    chk({tag, "_excess_accepted"}, extra, 0);
    chk({tag, "_done_delay"}, dc - last_wr_cyc, POST);
    chk({tag, "_write_count"}, wr_cnt, IMG);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_core_reset"}, CORE_RESET, 0);
    chk({tag, "_busy"}, DL_BUSY, 0);
    chk({tag, "_tno"}, TNO, tno);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_vals("reset");
    RESET = 1'b0;
    tick();
    chk_reset_vals("idle");
    chk("romcl_high", ROMCL, 1);

    // Full image, continuous valid: writes exactly GAP cycles apart.
    strict_gap = 1'b1;
    do_start(4'd5);
    chk("load_busy", DL_BUSY, 1);
    chk("load_ready", DL_READY, 1);
    send_bytes(IMG, 100);
    chk_complete("full", 4'd5);
    DL_END = 1'b1;
    tick();
    DL_END = 1'b0;
    tick();
    chk("end_in_done_ignored", DL_DONE, 1);
    chk("end_in_done_no_err", DL_ERR, 0);

    // Short image: stream stops, writes drain, then DL_END.
    strict_gap = 1'b0;
    do_start(4'd3);
    chk("restart_clears_done", DL_DONE, 0);
    chk("restart_core_reset", CORE_RESET, 1);
    send_bytes(17'h100, 70);
    repeat (20) tick();
    DL_END = 1'b1;
    tick();
    DL_END = 1'b0;
    tick();
    chk("short_err", DL_ERR, 1);
    chk("short_core_reset", CORE_RESET, 1);
    chk("short_ready", DL_READY, 0);
    chk("short_busy", DL_BUSY, 0);
    chk("short_write_count", wr_cnt, 17'h100);
    repeat (10) tick();
    chk("short_pending", exp_q.size(), 0);

    // Restart mid-LOAD with a new type number, then complete with random valid.
    do_start(4'd0);
    chk("restart_clears_err", DL_ERR, 0);
    send_bytes(17'h200, 80);
    chk("mid_load_tno", TNO, 0);
    do_start(4'd5);
    chk("relatch_tno", TNO, 5);
    send_bytes(IMG, 60);
    chk_complete("restart", 4'd5);

    // Asynchronous reset while draining.
    do_start(4'd9);
    send_bytes(IMG, 100);
    tick();
    chk("drain_busy", DL_BUSY, 1);
    #2;
    RESET = 1'b1;
    epoch++;
    wr_epoch = epoch;
    exp_q.delete();
    #1;
    chk_reset_vals("async_reset");
    repeat (3) tick();
    RESET = 1'b0;
    repeat (30) tick();
    chk("post_reset_idle_busy", DL_BUSY, 0);
    chk("post_reset_ready", DL_READY, 0);
    chk("post_reset_core_reset", CORE_RESET, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
